xadc_drp_responder: RTL and testbench
=====================================

# xadc_drp_responder

Synthesizable stand-in for the XADC's Dynamic Reconfiguration Port (DRP) slave side. It answers DRP reads and writes from an initiator with a fixed-latency `drdy_out` handshake. It also runs a two-channel conversion sequencer (VAUX6/VAUX7) that turns digital sample inputs into result registers with `eoc_out`/`channel_out`/`busy_out` timing. It replaces the XADC primitive in simulation and on boards without analog inputs, so joystick-side logic can run unchanged.

## Interface
- `DRP_LATENCY`, 4: cycles from accepted `den_in` to `drdy_out`; legal range 2–15.
- `CONV_CYCLES`, 26: cycles per conversion; legal range 4–255.
- `clk_100MHz`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `daddr_in`  in  7  DRP register address.
- `den_in`  in  1  DRP enable, one-cycle strobe.
- `dwe_in`  in  1  DRP write enable, qualified by `den_in`.
- `di_in`  in  16  DRP write data.
- `sample_x`  in  12  digital value standing in for VAUX6.
- `sample_y`  in  12  digital value standing in for VAUX7.
- `do_out`  out  16  DRP read data.
- `drdy_out`  out  1  DRP transaction-complete pulse.
- `busy_out`  out  1  conversion in progress.
- `eoc_out`  out  1  end-of-conversion pulse.
- `channel_out`  out  7  address of the channel just converted.
- `drp_err_out`  out  1  pulse on a `den_in` that was rejected.

## Operation
- **Register map**
  - 0x16: VAUX6 result, read-only, `{sample, 4'h0}`.
  - 0x17: VAUX7 result, read-only, `{sample, 4'h0}`.
  - 0x40, 0x41, 0x42: config, read/write; reset values 0x0000, 0x0000, 0x0400.
  - 0x41 bit0 = `seq_hold`.
  - Any other address reads 0x0000. Writes to other addresses and to 0x16/0x17 are ignored, but still complete with `drdy_out`.
- **DRP FSM states:** IDLE → WAIT → RESP → IDLE.
  - IDLE: `den_in`=1 latches `daddr_in`, `dwe_in` and `di_in`, then moves to WAIT. The countdown is loaded with `DRP_LATENCY`-1.
  - WAIT: decrements the countdown. At 1, moves to RESP.
  - RESP: drives `drdy_out`=1 for exactly one cycle, then returns to IDLE.
    - Read: `do_out` is loaded with register contents as they stood before that edge.
    - Write: the register is updated on that edge and `do_out` is loaded with 0x0000.
  - `do_out` holds its value until the next response.
  - `den_in`=1 in WAIT or RESP is ignored. `drp_err_out` pulses for one cycle and the in-flight transaction is unaffected.
  - `dwe_in` without `den_in` has no effect.
- **Sequencer states:** CONV → CONV (next channel) | HOLD.
  - Starts converting VAUX6 on the first cycle after reset release, then alternates 6, 7, 6, …
  - On the last cycle of each conversion:
    - the current `sample_x` or `sample_y` is captured into its result register;
    - `eoc_out` pulses for one cycle;
    - `channel_out` is set to 7'h16 or 7'h17 and held until the next EOC.
  - `busy_out` is 1 throughout CONV and 0 in HOLD.
  - When `seq_hold`=1 at an EOC, the sequencer enters HOLD. Clearing `seq_hold` restarts it with the next channel in the rotation.
- **Reset:** asserting `rst_n` at any point aborts the pending DRP transaction (no `drdy_out`) and the current conversion. All registers return to their reset values.

## Timing
- **Output reset values:** `do_out`=0, `drdy_out`=0, `busy_out`=0, `eoc_out`=0, `channel_out`=0, `drp_err_out`=0.
- **DRP latency:** `den_in` sampled at edge N gives `drdy_out`=1 during cycle N+`DRP_LATENCY`. The next `den_in` is accepted at N+`DRP_LATENCY`+1 at the earliest; a `den_in` during the `drdy_out` cycle is rejected.
- **Conversion timing:** first `eoc_out` at cycle `CONV_CYCLES` after reset release, then every `CONV_CYCLES` cycles.
- **Read/update collision:** a read whose RESP edge coincides with a result capture returns the old value.
- All outputs are registered.

## Structure
- **Shared package `xadc_drp_pkg`:**
  - address constants 0x16, 0x17, 0x40–0x42;
  - config reset values;
  - the `seq_hold` bit index;
  - DRP FSM and sequencer state enums.
- **Sub-module `xadc_conv_sequencer`:** conversion counter, channel rotation, result capture, EOC/busy generation. It exports both result registers and accepts `seq_hold` as an input.
- The top level keeps the DRP FSM, config registers and read mux.

## Test plan
- **Result readback:** reset, `sample_x`=0xABC, `sample_y`=0x123, wait two EOCs. Read 0x16 at N → `drdy_out` at N+4 with `do_out`=0xABC0. Read 0x17 → 0x1230.
- **EOC cadence:** after reset release, `eoc_out` pulses at cycle 26 with `channel_out`=0x16 and at cycle 52 with `channel_out`=0x17. `busy_out` stays 1 throughout.
- **Config write/readback:** write 0x40 with `di_in`=0x5A5A → `drdy_out` at N+4 with `do_out`=0x0000. Reading 0x40 returns 0x5A5A. Writing 0x16 with 0xFFFF leaves 0x16 unchanged. Reading 0x7F returns 0x0000.
- **Rejected request:** `den_in` at N and again at N+2 → `drp_err_out` high only at N+2, a single `drdy_out` at N+4 with the first address's data.
- **Sequencer hold:** write 0x41 = 0x0001 → after the next EOC no further `eoc_out` and `busy_out`=0. Write 0x0000 → conversions resume on the other channel, with EOC `CONV_CYCLES` later.
- **Reset mid-transaction:** drop `rst_n` at N+2 of a read → no `drdy_out`. All outputs return to reset values, config 0x42 reads 0x0400 after release, and the first EOC lands at cycle 26.

Source files
------------

// File: rtl/xadc_drp_pkg.sv
// Shared constants and state types for the XADC DRP stand-in.
package xadc_drp_pkg;

  localparam logic [6:0] ADDR_VAUX6 = 7'h16;
  localparam logic [6:0] ADDR_VAUX7 = 7'h17;
  localparam logic [6:0] ADDR_CFG0  = 7'h40;
  localparam logic [6:0] ADDR_CFG1  = 7'h41;
  localparam logic [6:0] ADDR_CFG2  = 7'h42;

  localparam logic [15:0] CFG0_RST = 16'h0000;
  localparam logic [15:0] CFG1_RST = 16'h0000;
  localparam logic [15:0] CFG2_RST = 16'h0400;

  localparam int SEQ_HOLD_BIT = 0;

  typedef enum logic [1:0] {DRP_IDLE, DRP_WAIT, DRP_RESP} drp_state_e;
  typedef enum logic {SEQ_CONV, SEQ_HOLD} seq_state_e;

endpackage

// File: rtl/xadc_conv_sequencer.sv
// Two-channel conversion sequencer: alternates VAUX6/VAUX7, captures the
// digital sample on the last cycle of each conversion and pulses EOC.
module xadc_conv_sequencer
  import xadc_drp_pkg::*;
#(
  parameter int CONV_CYCLES = 26
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [11:0]      sample_x_i,
  input  logic [11:0]      sample_y_i,
  input  logic             seq_hold_i,
  output logic [1:0][11:0] result_o,
  output logic             busy_o,
  output logic             eoc_o,
  output logic [6:0]       channel_o
);

  localparam int CW = $clog2(CONV_CYCLES);
  // Capture is registered one edge early so EOC is visible in the last cycle.
  localparam logic [CW-1:0] CAP_CNT  = CW'(CONV_CYCLES - 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CONV_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ch_q, ch_d;       // 0: VAUX6, 1: VAUX7
  logic [1:0][11:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             eoc_q, eoc_d;
  logic [6:0]       chan_q, chan_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    res_d   = res_q;
    busy_d  = busy_q;
    eoc_d   = 1'b0;
    chan_d  = chan_q;
    unique case (state_q)
      SEQ_CONV: begin
        busy_d = 1'b1;
        cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CAP_CNT) begin
          eoc_d       = 1'b1;
          ch_d        = ~ch_q;
          chan_d      = ch_q ? ADDR_VAUX7 : ADDR_VAUX6;
          res_d[ch_q] = ch_q ? sample_y_i : sample_x_i;
          if (seq_hold_i) begin
            state_d = SEQ_HOLD;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      SEQ_HOLD: begin
        busy_d = 1'b0;
        if (!seq_hold_i) begin
          state_d = SEQ_CONV;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = SEQ_CONV;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEQ_CONV;
      cnt_q   <= '0;
      ch_q    <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      eoc_q   <= 1'b0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      eoc_q   <= eoc_d;
      chan_q  <= chan_d;
    end
  end

  assign result_o  = res_q;
  assign busy_o    = busy_q;
  assign eoc_o     = eoc_q;
  assign channel_o = chan_q;

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC DRP slave stand-in: fixed-latency DRP handshake, config registers,
// read mux and the VAUX6/VAUX7 conversion sequencer.
module xadc_drp_responder
  import xadc_drp_pkg::*;
#(
  parameter int DRP_LATENCY = 4,
  parameter int CONV_CYCLES = 26
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        busy_out,
  output logic        eoc_out,
  output logic [6:0]  channel_out,
  output logic        drp_err_out
);

  localparam logic [3:0] LAT_LOAD = 4'(DRP_LATENCY - 1);

  drp_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] do_q, do_d;
  logic        drdy_q, drdy_d;
  logic        err_q, err_d;
  logic [15:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic [15:0] rd_data;

  logic [1:0][11:0] result;

  xadc_conv_sequencer #(.CONV_CYCLES(CONV_CYCLES)) u_seq (
    .clk_i      (clk_100MHz),
    .rst_ni     (rst_n),
    .sample_x_i (sample_x),
    .sample_y_i (sample_y),
    .seq_hold_i (cfg1_q[SEQ_HOLD_BIT]),
    .result_o   (result),
    .busy_o     (busy_out),
    .eoc_o      (eoc_out),
    .channel_o  (channel_out)
  );

  always_comb begin
    rd_data = '0;
    case (addr_q)
      ADDR_VAUX6: rd_data = {result[0], 4'h0};
      ADDR_VAUX7: rd_data = {result[1], 4'h0};
      ADDR_CFG0:  rd_data = cfg0_q;
      ADDR_CFG1:  rd_data = cfg1_q;
      ADDR_CFG2:  rd_data = cfg2_q;
      default:    rd_data = '0;
    endcase
  end

  // The response (drdy, read data, register write) is committed on the edge
  // that enters RESP; RESP itself is the cycle drdy_out is visible.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    do_d    = do_q;
    drdy_d  = 1'b0;
    err_d   = 1'b0;
    cfg0_d  = cfg0_q;
    cfg1_d  = cfg1_q;
    cfg2_d  = cfg2_q;
    unique case (state_q)
      DRP_IDLE: begin
        if (den_in) begin
          addr_d  = daddr_in;
          we_d    = dwe_in;
          wdata_d = di_in;
          cnt_d   = LAT_LOAD;
          state_d = DRP_WAIT;
        end
      end
      DRP_WAIT: begin
        err_d = den_in;
        if (cnt_q == 4'd1) begin
          state_d = DRP_RESP;
          drdy_d  = 1'b1;
          if (we_q) begin
            do_d = '0;
            case (addr_q)
              ADDR_CFG0: cfg0_d = wdata_q;
              ADDR_CFG1: cfg1_d = wdata_q;
              ADDR_CFG2: cfg2_d = wdata_q;
              default:   ;
            endcase
          end else begin
            do_d = rd_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DRP_RESP: begin
        err_d   = den_in;
        state_d = DRP_IDLE;
      end
      default: state_d = DRP_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRP_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      do_q    <= '0;
      drdy_q  <= 1'b0;
      err_q   <= 1'b0;
      cfg0_q  <= CFG0_RST;
      cfg1_q  <= CFG1_RST;
      cfg2_q  <= CFG2_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      do_q    <= do_d;
      drdy_q  <= drdy_d;
      err_q   <= err_d;
      cfg0_q  <= cfg0_d;
      cfg1_q  <= cfg1_d;
      cfg2_q  <= cfg2_d;
    end
  end

  assign do_out      = do_q;
  assign drdy_out    = drdy_q;
  assign drp_err_out = err_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Randomized self-checking bench for xadc_drp_responder against a
// transaction-level model of the register map and conversion schedule.
module tb_xadc_drp_responder;

  localparam int LAT  = 4;
  localparam int CONV = 26;

  logic        clk_100MHz = 1'b0;
  logic        rst_n;
  logic [6:0]  daddr_in;
  logic        den_in, dwe_in;
  logic [15:0] di_in;
  logic [11:0] sample_x, sample_y;
  logic [15:0] do_out;
  logic        drdy_out, busy_out, eoc_out, drp_err_out;
  logic [6:0]  channel_out;

  int n_chk = 0;
  int n_err = 0;

  // Model state: config registers and the last captured samples.
  logic [15:0] m_cfg0, m_cfg1, m_cfg2;
  logic [11:0] m_x, m_y;

  xadc_drp_responder #(.DRP_LATENCY(LAT), .CONV_CYCLES(CONV)) dut (
    .clk_100MHz  (clk_100MHz),
    .rst_n       (rst_n),
    .daddr_in    (daddr_in),
    .den_in      (den_in),
    .dwe_in      (dwe_in),
    .di_in       (di_in),
    .sample_x    (sample_x),
    .sample_y    (sample_y),
    .do_out      (do_out),
    .drdy_out    (drdy_out),
    .busy_out    (busy_out),
    .eoc_out     (eoc_out),
    .channel_out (channel_out),
    .drp_err_out (drp_err_out)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  function automatic logic [15:0] model_rd(input logic [6:0] a);
    case (a)
      7'h16:   return {m_x, 4'h0};
      7'h17:   return {m_y, 4'h0};
      7'h40:   return m_cfg0;
      7'h41:   return m_cfg1;
      7'h42:   return m_cfg2;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic void model_reset();
    m_cfg0 = 16'h0000; m_cfg1 = 16'h0000; m_cfg2 = 16'h0400;
    m_x = '0; m_y = '0;
  endfunction

  // den sampled at edge N; drdy must be visible from edge N+LAT-1 (cycle N+LAT).
  task automatic drp(input logic [6:0] a, input logic we, input logic [15:0] d,
                     output logic [15:0] rd);
    int lat;
    daddr_in = a; dwe_in = we; di_in = d; den_in = 1'b1;
    step();
    den_in = 1'b0; dwe_in = 1'b0;
    lat = 0;
    while (drdy_out !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("drdy_latency", lat, LAT - 1);
    rd = do_out;
    step();
    chk("drdy_width", drdy_out, 1'b0);
    if (we) begin
      case (a)
        7'h40: m_cfg0 = d;
        7'h41: m_cfg1 = d;
        7'h42: m_cfg2 = d;
        default: ;
      endcase
    end
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a);
    logic [15:0] rd;
    drp(a, 1'b0, 16'h0, rd);
    chk(tag, rd, model_rd(a));
  endtask

  task automatic wr_chk(input string tag, input logic [6:0] a, input logic [15:0] d);
    logic [15:0] rd;
    drp(a, 1'b1, d, rd);
    chk(tag, rd, 16'h0000);
  endtask

  task automatic wait_eoc();
    int n = 0;
    while (eoc_out === 1'b1) step();
    while (eoc_out !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("eoc_wait", (n < 200), 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_do"},   do_out, 16'h0);
    chk({tag, "_drdy"}, drdy_out, 1'b0);
    chk({tag, "_busy"}, busy_out, 1'b0);
    chk({tag, "_eoc"},  eoc_out, 1'b0);
    chk({tag, "_chan"}, channel_out, 7'h0);
    chk({tag, "_err"},  drp_err_out, 1'b0);
  endtask

  // Runs n edges after reset release; reports first two EOC edges and channels.
  task automatic eoc_cadence(input int n, output int e1, output int e2,
                             output logic [6:0] c1, output logic [6:0] c2,
                             output int n_eoc, output int busy_low, output int n_drdy);
    e1 = -1; e2 = -1; c1 = '0; c2 = '0; n_eoc = 0; busy_low = 0; n_drdy = 0;
    for (int e = 1; e <= n; e++) begin
      step();
      if (eoc_out === 1'b1) begin
        n_eoc++;
        if (e1 < 0) begin e1 = e; c1 = channel_out; end
        else if (e2 < 0) begin e2 = e; c2 = channel_out; end
      end
      if (busy_out !== 1'b1) busy_low++;
      if (drdy_out === 1'b1) n_drdy++;
    end
  endtask

  initial begin
    int e1, e2, n_eoc, busy_low, n_drdy, k;
    logic [6:0] c1, c2, held_ch, a;
    logic [15:0] rd, d;
    logic [11:0] sx, sy;

    rst_n = 1'b0; den_in = 1'b0; dwe_in = 1'b0; daddr_in = '0; di_in = '0;
    sample_x = 12'hABC; sample_y = 12'h123;
    model_reset();
    repeat (3) step();
    chk_reset_outputs("reset");

    // EOC cadence: EOC of cycle k is visible between edges k-1 and k.
    rst_n = 1'b1;
    eoc_cadence(60, e1, e2, c1, c2, n_eoc, busy_low, n_drdy);
    chk("eoc1_edge", e1, CONV - 1);
    chk("eoc1_chan", c1, 7'h16);
    chk("eoc2_edge", e2, 2 * CONV - 1);
    chk("eoc2_chan", c2, 7'h17);
    chk("eoc_count", n_eoc, 2);
    chk("busy_low_cycles", busy_low, 0);
    m_x = 12'hABC; m_y = 12'h123;

    rd_chk("rd_vaux6", 7'h16);
    rd_chk("rd_vaux7", 7'h17);
    rd_chk("rd_cfg2_rst", 7'h42);

    wr_chk("wr_cfg0_do", 7'h40, 16'h5A5A);
    rd_chk("rd_cfg0", 7'h40);
    wr_chk("wr_vaux6_do", 7'h16, 16'hFFFF);
    rd_chk("rd_vaux6_ro", 7'h16);
    rd_chk("rd_unmapped_7f", 7'h7F);

    // Second den while the first is in flight is rejected.
    daddr_in = 7'h40; dwe_in = 1'b0; den_in = 1'b1;
    step();                                   // edge N
    den_in = 1'b0;
    step();                                   // edge N+1
    chk("rej_err_n1", drp_err_out, 1'b0);
    daddr_in = 7'h17; dwe_in = 1'b1; di_in = 16'h1111; den_in = 1'b1;
    step();                                   // edge N+2
    den_in = 1'b0; dwe_in = 1'b0;
    chk("rej_err_n2", drp_err_out, 1'b1);
    chk("rej_drdy_n2", drdy_out, 1'b0);
    step();                                   // edge N+3
    chk("rej_err_n3", drp_err_out, 1'b0);
    chk("rej_drdy_n3", drdy_out, 1'b1);
    chk("rej_data", do_out, 16'h5A5A);
    step();
    chk("rej_single_drdy", drdy_out, 1'b0);

    // Randomized samples and register traffic.
    for (int it = 0; it < 6; it++) begin
      sx = 12'($urandom_range(0, 4095));
      sy = 12'($urandom_range(0, 4095));
      sample_x = sx; sample_y = sy;
      wait_eoc();
      wait_eoc();
      m_x = sx; m_y = sy;
      rd_chk("rand_vaux6", 7'h16);
      rd_chk("rand_vaux7", 7'h17);
      a = ($urandom_range(0, 1) == 0) ? 7'h40 : 7'h42;
      d = 16'($urandom);
      wr_chk("rand_wr_do", a, d);
      rd_chk("rand_cfg", a);
      wr_chk("rand_wr41_do", 7'h41, 16'($urandom) & 16'hFFFE);
      rd_chk("rand_cfg41", 7'h41);
      do a = 7'($urandom_range(0, 127));
      while (a == 7'h16 || a == 7'h17 || a == 7'h40 || a == 7'h41 || a == 7'h42);
      rd_chk("rand_unmapped", a);
    end

    // Sequencer hold and resume.
    wr_chk("hold_wr_do", 7'h41, 16'h0001);
    repeat (30) step();
    chk("hold_busy", busy_out, 1'b0);
    held_ch = channel_out;
    n_eoc = 0; busy_low = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (eoc_out === 1'b1) n_eoc++;
      if (busy_out === 1'b1) busy_low++;
    end
    chk("hold_no_eoc", n_eoc, 0);
    chk("hold_busy_cycles", busy_low, 0);
    wr_chk("resume_wr_do", 7'h41, 16'h0000);
    k = 0;
    while (eoc_out !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk("resume_latency", k, CONV - 1);
    chk("resume_chan", channel_out, (held_ch == 7'h16) ? 7'h17 : 7'h16);
    chk("resume_busy", busy_out, 1'b1);

    // Reset in the middle of a read: no drdy, everything back to reset.
    wr_chk("pre_rst_wr", 7'h42, 16'hBEEF);
    daddr_in = 7'h16; dwe_in = 1'b0; den_in = 1'b1;
    step();                                   // edge N
    den_in = 1'b0;
    step();
    step();                                   // edge N+2
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    n_drdy = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (drdy_out === 1'b1) n_drdy++;
    end
    chk("midrst_no_drdy", n_drdy, 0);
    model_reset();
    rst_n = 1'b1;
    eoc_cadence(CONV + 2, e1, e2, c1, c2, n_eoc, busy_low, n_drdy);
    chk("post_rst_eoc_edge", e1, CONV - 1);
    chk("post_rst_eoc_chan", c1, 7'h16);
    chk("post_rst_no_drdy", n_drdy, 0);
    m_x = sample_x;
    rd_chk("post_rst_cfg2", 7'h42);
    rd_chk("post_rst_cfg0", 7'h40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
